// File: rtl/rf_issue_scoreboard_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_issue_scoreboard_if: decode/issue/writeback bundle of the scoreboard  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface rf_issue_scoreboard_if #(
  parameter int STAT_W = 32
);
  logic              issue_ready;
  logic              i0_valid;
  logic              i0_rs_ren;
  logic [4:0]        i0_rs;
  logic              i0_rt_ren;
  logic [4:0]        i0_rt;
  logic              i0_wen;
  logic [4:0]        i0_dst;
  logic              i1_valid;
  logic              i1_rs_ren;
  logic [4:0]        i1_rs;
  logic              i1_rt_ren;
  logic [4:0]        i1_rt;
  logic              i1_wen;
  logic [4:0]        i1_dst;
  logic              wb0_we;
  logic [4:0]        wb0_addr;
  logic              wb1_we;
  logic [4:0]        wb1_addr;
  logic              flush;
  logic              issue0;
  logic              issue1;
  logic              pending_any;
  logic              err;
  logic [STAT_W-1:0] stall_cnt;

  modport master (
    output issue_ready, i0_valid, i0_rs_ren, i0_rs, i0_rt_ren, i0_rt, i0_wen, i0_dst,
           i1_valid, i1_rs_ren, i1_rs, i1_rt_ren, i1_rt, i1_wen, i1_dst,
           wb0_we, wb0_addr, wb1_we, wb1_addr, flush,
    input  issue0, issue1, pending_any, err, stall_cnt
  );

  modport slave (
    input  issue_ready, i0_valid, i0_rs_ren, i0_rs, i0_rt_ren, i0_rt, i0_wen, i0_dst,
           i1_valid, i1_rs_ren, i1_rs, i1_rt_ren, i1_rt, i1_wen, i1_dst,
           wb0_we, wb0_addr, wb1_we, wb1_addr, flush,
    output issue0, issue1, pending_any, err, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/rf_issue_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_issue_scoreboard: per-register pending-write scoreboard, dual issue   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rf_issue_scoreboard #(
  parameter int CNT_W  = 2,
  parameter int STAT_W = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  rf_issue_scoreboard_if.slave   sb
);
  localparam logic [CNT_W+1:0] c_MAX = (CNT_W+2)'((1 << CNT_W) - 1);

  // Entry 0 stays zero so r0 never looks pending.
  logic [CNT_W-1:0]  r_cnt     [32];
  logic [CNT_W-1:0]  w_cnt_nxt [32];
  logic              r_err;
  logic              r_pend;
  logic [STAT_W-1:0] r_stall;

  logic              w_hz0, w_hz1, w_full0, w_full1, w_raw, w_same;
  logic              w_issue0, w_issue1;
  logic [CNT_W+1:0]  w_need0, w_need1;
  logic [CNT_W+1:0]  w_sum, w_dec;
  logic              w_uf, w_any;

  assign w_hz0 = (sb.i0_rs_ren && sb.i0_rs != 5'd0 && r_cnt[sb.i0_rs] != '0) ||
                 (sb.i0_rt_ren && sb.i0_rt != 5'd0 && r_cnt[sb.i0_rt] != '0);
  assign w_hz1 = (sb.i1_rs_ren && sb.i1_rs != 5'd0 && r_cnt[sb.i1_rs] != '0) ||
                 (sb.i1_rt_ren && sb.i1_rt != 5'd0 && r_cnt[sb.i1_rt] != '0);

  // Slot 1 capacity check accounts for slot 0 writing the same destination.
  assign w_same  = sb.i0_wen && (sb.i0_dst == sb.i1_dst);
  assign w_need0 = (CNT_W+2)'(r_cnt[sb.i0_dst]) + (CNT_W+2)'(1);
  assign w_need1 = (CNT_W+2)'(r_cnt[sb.i1_dst]) + (CNT_W+2)'(1) + (CNT_W+2)'(w_same);
  assign w_full0 = sb.i0_wen && sb.i0_dst != 5'd0 && (w_need0 > c_MAX);
  assign w_full1 = sb.i1_wen && sb.i1_dst != 5'd0 && (w_need1 > c_MAX);

  assign w_raw = sb.i0_wen && sb.i0_dst != 5'd0 &&
                 ((sb.i1_rs_ren && sb.i1_rs == sb.i0_dst) ||
                  (sb.i1_rt_ren && sb.i1_rt == sb.i0_dst));

  assign w_issue0 = sb.issue_ready && sb.i0_valid && !sb.flush && !w_hz0 && !w_full0;
  assign w_issue1 = w_issue0 && sb.i1_valid && !w_hz1 && !w_full1 && !w_raw;

  always_comb begin
    w_uf  = 1'b0;
    w_any = 1'b0;
    w_sum = '0;
    w_dec = '0;
    for (int r = 0; r < 32; r++) begin
      w_cnt_nxt[r] = '0;
      if (r != 0 && !sb.flush) begin
        w_sum = (CNT_W+2)'(r_cnt[r])
              + (CNT_W+2)'(w_issue0 && sb.i0_wen && sb.i0_dst == 5'(r))
              + (CNT_W+2)'(w_issue1 && sb.i1_wen && sb.i1_dst == 5'(r));
        w_dec = (CNT_W+2)'(sb.wb0_we && sb.wb0_addr == 5'(r))
              + (CNT_W+2)'(sb.wb1_we && sb.wb1_addr == 5'(r));
        if (w_sum < w_dec) begin
          w_uf = 1'b1;
        end else begin
          w_cnt_nxt[r] = CNT_W'(w_sum - w_dec);
        end
      end
      w_any = w_any | (w_cnt_nxt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= '{default: '0};
      r_err   <= 1'b0;
      r_pend  <= 1'b0;
      r_stall <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_pend <= w_any;
      if (w_uf) begin
        r_err <= 1'b1;
      end
      if (sb.i0_valid && sb.issue_ready && !w_issue0 && !sb.flush) begin
        r_stall <= r_stall + STAT_W'(1);
      end
    end
  end

  assign sb.issue0      = w_issue0;
  assign sb.issue1      = w_issue1;
  assign sb.pending_any = r_pend;
  assign sb.err         = r_err;
  assign sb.stall_cnt   = r_stall;
endmodule
`default_nettype wire

// File: tb/tb_rf_issue_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rf_issue_scoreboard: directed + randomized bench with reference model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rf_issue_scoreboard;
  localparam int c_CNT_W  = 2;
  localparam int c_STAT_W = 32;
  localparam int c_MAX    = (1 << c_CNT_W) - 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  rf_issue_scoreboard_if #(.STAT_W(c_STAT_W)) sb ();

  rf_issue_scoreboard #(.CNT_W(c_CNT_W), .STAT_W(c_STAT_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sb     (sb)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: plain integer counts per architectural register.
  int          m_cnt [32];
  bit          m_err;
  bit          m_pend;
  logic [31:0] m_stall;

  function automatic void model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_err = 0; m_pend = 0; m_stall = 32'd0;
  endfunction

  function automatic bit reads_busy(bit ren, logic [4:0] a);
    return ren && a != 0 && m_cnt[a] > 0;
  endfunction

  function automatic void model_issue(output bit e0, output bit e1);
    int writers;
    bit busy0, busy1, full0, full1, raw;
    busy0 = reads_busy(sb.i0_rs_ren, sb.i0_rs) || reads_busy(sb.i0_rt_ren, sb.i0_rt);
    busy1 = reads_busy(sb.i1_rs_ren, sb.i1_rs) || reads_busy(sb.i1_rt_ren, sb.i1_rt);
    full0 = sb.i0_wen && sb.i0_dst != 0 && (m_cnt[sb.i0_dst] + 1 > c_MAX);
    writers = 1 + ((sb.i0_wen && sb.i0_dst == sb.i1_dst) ? 1 : 0);
    full1 = sb.i1_wen && sb.i1_dst != 0 && (m_cnt[sb.i1_dst] + writers > c_MAX);
    raw = sb.i0_wen && sb.i0_dst != 0 &&
          ((sb.i1_rs_ren && sb.i1_rs == sb.i0_dst) || (sb.i1_rt_ren && sb.i1_rt == sb.i0_dst));
    e0 = sb.issue_ready && sb.i0_valid && !sb.flush && !busy0 && !full0;
    e1 = e0 && sb.i1_valid && !busy1 && !full1 && !raw;
  endfunction

  function automatic void model_step();
    bit e0, e1;
    int v;
    model_issue(e0, e1);
    if (sb.i0_valid && sb.issue_ready && !e0 && !sb.flush) m_stall = m_stall + 32'd1;
    m_pend = 0;
    for (int r = 1; r < 32; r++) begin
      if (sb.flush) begin
        m_cnt[r] = 0;
      end else begin
        v = m_cnt[r];
        if (e0 && sb.i0_wen && sb.i0_dst == r) v++;
        if (e1 && sb.i1_wen && sb.i1_dst == r) v++;
        if (sb.wb0_we && sb.wb0_addr == r) v--;
        if (sb.wb1_we && sb.wb1_addr == r) v--;
        if (v < 0) begin
          v = 0;
          m_err = 1;
        end
        m_cnt[r] = v;
      end
      if (m_cnt[r] != 0) m_pend = 1;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sb.issue_ready = 1'b1;
    sb.i0_valid = 0; sb.i0_rs_ren = 0; sb.i0_rs = 0; sb.i0_rt_ren = 0; sb.i0_rt = 0;
    sb.i0_wen = 0; sb.i0_dst = 0;
    sb.i1_valid = 0; sb.i1_rs_ren = 0; sb.i1_rs = 0; sb.i1_rt_ren = 0; sb.i1_rt = 0;
    sb.i1_wen = 0; sb.i1_dst = 0;
    sb.wb0_we = 0; sb.wb0_addr = 0; sb.wb1_we = 0; sb.wb1_addr = 0;
    sb.flush = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (sb.pending_any !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b exp=0", sb.pending_any); end
    total++; if (sb.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", sb.err); end
    total++; if (sb.stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", sb.stall_cnt); end
  endtask

  task automatic test_single_writer();
    clear_inputs();
    sb.i0_valid = 1; sb.i0_wen = 1; sb.i0_dst = 5;
    #1;
    total++; if (sb.issue0 !== 1'b1) begin bad++; $display("FAIL sw_issue got=%b exp=1", sb.issue0); end
    tick();
    total++; if (sb.pending_any !== 1'b1) begin bad++; $display("FAIL sw_pending got=%b exp=1", sb.pending_any); end
    sb.i0_wen = 0; sb.i0_rs_ren = 1; sb.i0_rs = 5;
    #1;
    total++; if (sb.issue0 !== 1'b0) begin bad++; $display("FAIL sw_hazard got=%b exp=0", sb.issue0); end
    tick(); tick();
    total++; if (sb.stall_cnt !== 32'd2) begin bad++; $display("FAIL sw_stall got=%0d exp=2", sb.stall_cnt); end
    sb.wb0_we = 1; sb.wb0_addr = 5;
    #1;
    total++; if (sb.issue0 !== 1'b0) begin bad++; $display("FAIL sw_no_bypass got=%b exp=0", sb.issue0); end
    tick();
    sb.wb0_we = 0;
    #1;
    total++; if (sb.issue0 !== 1'b1) begin bad++; $display("FAIL sw_after_wb got=%b exp=1", sb.issue0); end
    tick();
    total++; if (sb.pending_any !== 1'b0) begin bad++; $display("FAIL sw_drained got=%b exp=0", sb.pending_any); end
    total++; if (sb.stall_cnt !== 32'd3) begin bad++; $display("FAIL sw_stall_final got=%0d exp=3", sb.stall_cnt); end
  endtask

  task automatic test_intra_pair();
    clear_inputs();
    sb.i0_valid = 1; sb.i0_wen = 1; sb.i0_dst = 3;
    sb.i1_valid = 1; sb.i1_rt_ren = 1; sb.i1_rt = 3;
    #1;
    total++; if ({sb.issue0, sb.issue1} !== 2'b10) begin bad++; $display("FAIL pair_raw got=%b%b exp=10", sb.issue0, sb.issue1); end
    tick();
    clear_inputs();
    sb.wb0_we = 1; sb.wb0_addr = 3;
    tick();
    clear_inputs();
    sb.i0_valid = 1; sb.i0_wen = 1; sb.i0_dst = 0; sb.i0_rs_ren = 1;
    sb.i1_valid = 1; sb.i1_rs_ren = 1; sb.i1_rt_ren = 1; sb.i1_wen = 1;
    #1;
    total++; if ({sb.issue0, sb.issue1} !== 2'b11) begin bad++; $display("FAIL pair_r0 got=%b%b exp=11", sb.issue0, sb.issue1); end
    tick();
    total++; if (sb.pending_any !== 1'b0) begin bad++; $display("FAIL pair_r0_pending got=%b exp=0", sb.pending_any); end
  endtask

  task automatic test_waw_full();
    clear_inputs();
    sb.i0_valid = 1; sb.i0_wen = 1; sb.i0_dst = 7;
    tick();
    sb.i1_valid = 1; sb.i1_wen = 1; sb.i1_dst = 7;
    #1;
    total++; if ({sb.issue0, sb.issue1} !== 2'b11) begin bad++; $display("FAIL waw_pair got=%b%b exp=11", sb.issue0, sb.issue1); end
    tick();
    #1;
    total++; if ({sb.issue0, sb.issue1} !== 2'b00) begin bad++; $display("FAIL waw_full got=%b%b exp=00", sb.issue0, sb.issue1); end
    clear_inputs();
    sb.wb0_we = 1; sb.wb0_addr = 7; sb.wb1_we = 1; sb.wb1_addr = 7;
    tick();
    total++; if (sb.pending_any !== 1'b1) begin bad++; $display("FAIL waw_dual_wb got=%b exp=1", sb.pending_any); end
    clear_inputs();
    sb.wb0_we = 1; sb.wb0_addr = 7;
    tick();
    total++; if (sb.pending_any !== 1'b0) begin bad++; $display("FAIL waw_last_wb got=%b exp=0", sb.pending_any); end
    total++; if (sb.err !== 1'b0) begin bad++; $display("FAIL waw_err got=%b exp=0", sb.err); end
  endtask

  task automatic test_net_and_underflow();
    clear_inputs();
    sb.i0_valid = 1; sb.i0_wen = 1; sb.i0_dst = 9;
    tick();
    sb.wb1_we = 1; sb.wb1_addr = 9;
    #1;
    total++; if (sb.issue0 !== 1'b1) begin bad++; $display("FAIL net_issue got=%b exp=1", sb.issue0); end
    tick();
    total++; if (sb.pending_any !== 1'b1) begin bad++; $display("FAIL net_hold got=%b exp=1", sb.pending_any); end
    clear_inputs();
    sb.wb0_we = 1; sb.wb0_addr = 9;
    tick();
    total++; if (sb.err !== 1'b0) begin bad++; $display("FAIL net_count got=%b exp=0", sb.err); end
    sb.wb0_addr = 10;
    tick();
    total++; if (sb.err !== 1'b1) begin bad++; $display("FAIL uf_err got=%b exp=1", sb.err); end
    clear_inputs();
    tick(); tick();
    total++; if (sb.err !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%b exp=1", sb.err); end
    total++; if (sb.pending_any !== 1'b0) begin bad++; $display("FAIL uf_pending got=%b exp=0", sb.pending_any); end
  endtask

  task automatic test_flush();
    logic [31:0] s;
    clear_inputs();
    sb.i0_valid = 1; sb.i0_wen = 1; sb.i0_dst = 4;
    sb.i1_valid = 1; sb.i1_wen = 1; sb.i1_dst = 4;
    tick();
    clear_inputs();
    sb.i0_valid = 1; sb.i0_wen = 1; sb.i0_dst = 6;
    tick();
    sb.flush = 1; sb.i0_dst = 4;
    sb.i1_valid = 1; sb.i1_wen = 1; sb.i1_dst = 4;
    sb.wb0_we = 1; sb.wb0_addr = 4;
    s = sb.stall_cnt;
    #1;
    total++; if ({sb.issue0, sb.issue1} !== 2'b00) begin bad++; $display("FAIL flush_issue got=%b%b exp=00", sb.issue0, sb.issue1); end
    tick();
    total++; if (sb.pending_any !== 1'b0) begin bad++; $display("FAIL flush_pending got=%b exp=0", sb.pending_any); end
    total++; if (sb.stall_cnt !== s) begin bad++; $display("FAIL flush_stall got=%0d exp=%0d", sb.stall_cnt, s); end
    total++; if (sb.err !== 1'b1) begin bad++; $display("FAIL flush_err got=%b exp=1", sb.err); end
    clear_inputs();
    sb.i0_valid = 1; sb.i0_rs_ren = 1; sb.i0_rs = 4; sb.i0_rt_ren = 1; sb.i0_rt = 6;
    sb.i1_valid = 1; sb.i1_rs_ren = 1; sb.i1_rs = 6;
    #1;
    total++; if ({sb.issue0, sb.issue1} !== 2'b11) begin bad++; $display("FAIL flush_cleared got=%b%b exp=11", sb.issue0, sb.issue1); end
    tick();
  endtask

  task automatic test_random();
    bit e0, e1;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      sb.issue_ready = ($urandom_range(0, 7) != 0);
      sb.i0_valid  = ($urandom_range(0, 3) != 0);
      sb.i0_rs_ren = 1'($urandom); sb.i0_rs = 5'($urandom_range(0, 7));
      sb.i0_rt_ren = 1'($urandom); sb.i0_rt = 5'($urandom_range(0, 7));
      sb.i0_wen    = 1'($urandom); sb.i0_dst = 5'($urandom_range(0, 7));
      sb.i1_valid  = ($urandom_range(0, 3) != 0);
      sb.i1_rs_ren = 1'($urandom); sb.i1_rs = 5'($urandom_range(0, 7));
      sb.i1_rt_ren = 1'($urandom); sb.i1_rt = 5'($urandom_range(0, 7));
      sb.i1_wen    = 1'($urandom); sb.i1_dst = 5'($urandom_range(0, 7));
      sb.wb0_we    = 1'($urandom); sb.wb0_addr = 5'($urandom_range(0, 7));
      sb.wb1_we    = 1'($urandom); sb.wb1_addr = 5'($urandom_range(0, 7));
      sb.flush     = ($urandom_range(0, 24) == 0);
      #1;
      model_issue(e0, e1);
      total++; if (sb.issue0 !== e0) begin bad++; $display("FAIL rnd_issue0 n=%0d got=%b exp=%b", n, sb.issue0, e0); end
      total++; if (sb.issue1 !== e1) begin bad++; $display("FAIL rnd_issue1 n=%0d got=%b exp=%b", n, sb.issue1, e1); end
      tick();
      total++; if (sb.pending_any !== m_pend) begin bad++; $display("FAIL rnd_pending n=%0d got=%b exp=%b", n, sb.pending_any, m_pend); end
      total++; if (sb.err !== m_err) begin bad++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, sb.err, m_err); end
      total++; if (sb.stall_cnt !== m_stall) begin bad++; $display("FAIL rnd_stall n=%0d got=%0d exp=%0d", n, sb.stall_cnt, m_stall); end
    end
  endtask

  task automatic test_async_reset();
    clear_inputs();
    sb.i0_valid = 1; sb.i0_wen = 1; sb.i0_dst = 2;
    tick();
    sb.wb0_we = 1; sb.wb0_addr = 12;
    sb.i0_wen = 0; sb.i0_rs_ren = 1; sb.i0_rs = 2;
    tick();
    total++; if (sb.pending_any !== 1'b1 || sb.err !== 1'b1) begin bad++; $display("FAIL ar_setup got=%b%b exp=11", sb.pending_any, sb.err); end
    #2;
    resetn = 1'b0;
    #1;
    total++; if (sb.pending_any !== 1'b0) begin bad++; $display("FAIL ar_pending got=%b exp=0", sb.pending_any); end
    total++; if (sb.err !== 1'b0) begin bad++; $display("FAIL ar_err got=%b exp=0", sb.err); end
    total++; if (sb.stall_cnt !== 32'd0) begin bad++; $display("FAIL ar_stall got=%0d exp=0", sb.stall_cnt); end
    #3;
    resetn = 1'b1;
    model_reset();
    clear_inputs();
    sb.i0_valid = 1; sb.i0_rs_ren = 1; sb.i0_rs = 2;
    #1;
    total++; if (sb.issue0 !== 1'b1) begin bad++; $display("FAIL ar_cleared got=%b exp=1", sb.issue0); end
    tick();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_single_writer();
    test_intra_pair();
    test_waw_full();
    test_net_and_underflow();
    test_flush();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
